bus_interface: RTL and testbench
================================

# bus_interface

Bus interface stage downstream of the core control state machine. It takes the encoded T-state and status bits produced by control and turns them into registered 8085-style pin activity: ALE, RD_/WR_/INTA_ strobes, the multiplexed AD bus drive/sample, the upper address byte and HLDA. It also synchronises the external READY and HOLD pins before they are fed back to control's `ipin`.

## Interface
- DATASIZE, 8, data/AD bus width
- ADDRSIZE, 16, address width; upper byte is ADDRSIZE-1:DATASIZE
- SYNC_STAGES, 2, flops in each READY/HOLD synchroniser (min 2)

- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- tstate  in  4  encoded T-state from control: TR=0, T1=1, T2=2, T3=3, T4=4, T5=5, T6=6, TH=7, TW=8, TT=9
- stat  in  3  [0]=S0, [1]=S1, [2]=IO/M_, from control `opin`
- addr  in  ADDRSIZE  cycle address, valid when tstate=T1
- dout  in  DATASIZE  write data, valid when tstate=T2
- ad_in  in  DATASIZE  sampled AD pins
- ready_pin  in  1  async READY pin
- hold_pin  in  1  async HOLD pin
- ipin  out  2  [0]=synchronised READY, [1]=synchronised HOLD, to control
- ale  out  1  address latch enable
- rd_n, wr_n, inta_n  out  1 each  active-low strobes
- ad_out  out  DATASIZE  AD drive value
- ad_oe  out  1  AD output enable
- a_hi  out  ADDRSIZE-DATASIZE  upper address pins
- a_oe  out  1  upper address / strobe enable (0 = tristate)
- din  out  DATASIZE  captured read data
- din_vld  out  1  one-cycle pulse, din updated
- hlda  out  1  hold acknowledge
- err  out  1  sticky: illegal tstate code (10-15) seen

## Operation
- Cycle type latched into `cyc` on T1 from stat: S1S0=11 fetch, 10 read, 01 write, 00 idle/halt. INTA = fetch with IO/M_=1. Strobe decode in T2/TW/T3 uses `cyc`, never live stat.
- T1: ale=1; a_hi=addr upper byte; ad_out=addr lower byte; ad_oe=1; a_oe=1; all strobes high.
- T2: ale=0. Read/fetch: ad_oe=0, rd_n=0 (inta_n=0 instead of rd_n for INTA). Write: ad_out=dout, ad_oe=1, wr_n=0. Idle: strobes high, ad_oe=0.
- TW: all outputs hold T2 values; insertion of waits is decided by control from ipin[0].
- T3: strobes hold. Read/fetch/INTA: din=ad_in, din_vld=1 for exactly one cycle. Write: no capture.
- T4/T5/T6: strobes high, ad_oe=0, ale=0; a_hi, a_oe unchanged.
- TH: strobes high, ad_oe=0, a_oe=0, hlda=1. Any other tstate: hlda=0.
- TT (halt): as TH but hlda=0.
- TR: all outputs at reset values except sync chains keep running.
- Illegal code 10-15: treated as TR, err=1 until reset.
- Synchronisers: ipin[0]/ipin[1] = ready_pin/hold_pin delayed SYNC_STAGES clocks; no glitch filtering.

## Timing
- All pin outputs registered: value visible after edge k reflects tstate/stat/addr/dout/ad_in sampled at edge k (latency 1).
- Strobes are flop outputs only; no combinational path inputs to outputs.
- rd_n/wr_n/inta_n low spans T2, every TW, T3 (2+N cycles, N = wait count); they rise on the edge sampling T4, T1, TH or TT.
- T1 immediately following T3 (back-to-back cycles): strobe rises and ale rises on the same edge.
- din_vld never high two consecutive cycles.
- Reset (rst=0 at edge, any state including mid-cycle): ale=0, rd_n=wr_n=inta_n=1, ad_oe=0, a_oe=0, ad_out=0, a_hi=0, din=0, din_vld=0, hlda=0, err=0, ipin=0, sync flops=0, cyc=idle. Active strobe released on that edge.

## Test plan
- Reset mid-write (tstate=T3, wr_n=0), rst=0 one edge -> next cycle wr_n=1, ad_oe=0, all outputs at reset values, err=0.
- Fetch addr=0x1234: T1,T2,T3,T4 -> ale=1 one cycle, a_hi=0x12, ad_out=0x34; rd_n=0 exactly 2 cycles; ad_in=0xA5 at T3 -> din=0xA5, din_vld pulse 1 cycle.
- Write addr=0x8001, dout=0x5A with 2 TW: T1,T2,TW,TW,T3 -> wr_n=0 for 4 cycles, ad_out=0x5A, ad_oe=1 throughout, din_vld never 1.
- INTA (stat=111) -> inta_n=0 for 2 cycles, rd_n stays 1, din captured.
- ready_pin 0->1 -> ipin[0]=1 exactly SYNC_STAGES cycles later; hold_pin then tstate=TH 3 cycles -> hlda=1, a_oe=0, ad_oe=0 those cycles, 0 after leaving.
- tstate=12 one cycle -> err=1 and stays 1 through later legal cycles until rst=0.

Source files
------------

// File: rtl/bus_interface.sv
// 8085-style bus pin stage: converts control's T-state and status into registered
// ALE / strobe / AD-bus activity and synchronises the READY and HOLD pins.
module bus_interface #(
   parameter int DATASIZE    = 8,
   parameter int ADDRSIZE    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [3:0]                   tstate,
   input  logic [2:0]                   stat,
   input  logic [ADDRSIZE-1:0]          addr,
   input  logic [DATASIZE-1:0]          dout,
   input  logic [DATASIZE-1:0]          ad_in,
   input  logic                         ready_pin,
   input  logic                         hold_pin,
   output logic [1:0]                   ipin,
   output logic                         ale,
   output logic                         rd_n,
   output logic                         wr_n,
   output logic                         inta_n,
   output logic [DATASIZE-1:0]          ad_out,
   output logic                         ad_oe,
   output logic [ADDRSIZE-DATASIZE-1:0] a_hi,
   output logic                         a_oe,
   output logic [DATASIZE-1:0]          din,
   output logic                         din_vld,
   output logic                         hlda,
   output logic                         err
);

   localparam logic [3:0] TS_TR = 4'd0;
   localparam logic [3:0] TS_T1 = 4'd1;
   localparam logic [3:0] TS_T2 = 4'd2;
   localparam logic [3:0] TS_T3 = 4'd3;
   localparam logic [3:0] TS_T4 = 4'd4;
   localparam logic [3:0] TS_T5 = 4'd5;
   localparam logic [3:0] TS_T6 = 4'd6;
   localparam logic [3:0] TS_TH = 4'd7;
   localparam logic [3:0] TS_TW = 4'd8;
   localparam logic [3:0] TS_TT = 4'd9;

   typedef enum logic [2:0] {
      CYC_IDLE,
      CYC_FETCH,
      CYC_READ,
      CYC_WRITE,
      CYC_INTA
   } cyc_e;

   cyc_e                          cyc_q, cyc_d;
   logic                          ale_q, ale_d;
   logic                          rd_n_q, rd_n_d;
   logic                          wr_n_q, wr_n_d;
   logic                          inta_n_q, inta_n_d;
   logic [DATASIZE-1:0]           ad_out_q, ad_out_d;
   logic                          ad_oe_q, ad_oe_d;
   logic [ADDRSIZE-DATASIZE-1:0]  a_hi_q, a_hi_d;
   logic                          a_oe_q, a_oe_d;
   logic [DATASIZE-1:0]           din_q, din_d;
   logic                          din_vld_q, din_vld_d;
   logic                          hlda_q, hlda_d;
   logic                          err_q, err_d;
   logic [SYNC_STAGES-1:0]        ready_sync_q, ready_sync_d;
   logic [SYNC_STAGES-1:0]        hold_sync_q, hold_sync_d;

   function automatic cyc_e decode_cyc(input logic [2:0] s);
      case (s[1:0])
         2'b11:   return s[2] ? CYC_INTA : CYC_FETCH;
         2'b10:   return CYC_READ;
         2'b01:   return CYC_WRITE;
         default: return CYC_IDLE;
      endcase
   endfunction

   always_comb begin
      // NOTE: every _d gets a default before the case so no path can infer a latch.
      cyc_d        = cyc_q;
      ale_d        = ale_q;
      rd_n_d       = rd_n_q;
      wr_n_d       = wr_n_q;
      inta_n_d     = inta_n_q;
      ad_out_d     = ad_out_q;
      ad_oe_d      = ad_oe_q;
      a_hi_d       = a_hi_q;
      a_oe_d       = a_oe_q;
      din_d        = din_q;
      din_vld_d    = 1'b0;
      hlda_d       = 1'b0;
      err_d        = err_q;
      ready_sync_d = {ready_sync_q[SYNC_STAGES-2:0], ready_pin};
      hold_sync_d  = {hold_sync_q[SYNC_STAGES-2:0], hold_pin};

      case (tstate)
         TS_T1: begin
            cyc_d    = decode_cyc(stat);
            ale_d    = 1'b1;
            a_hi_d   = addr[ADDRSIZE-1:DATASIZE];
            ad_out_d = addr[DATASIZE-1:0];
            ad_oe_d  = 1'b1;
            a_oe_d   = 1'b1;
            rd_n_d   = 1'b1;
            wr_n_d   = 1'b1;
            inta_n_d = 1'b1;
         end
         TS_T2: begin
            ale_d    = 1'b0;
            rd_n_d   = 1'b1;
            wr_n_d   = 1'b1;
            inta_n_d = 1'b1;
            ad_oe_d  = 1'b0;
            // Strobe choice comes from the cycle type latched at T1, not live stat.
            case (cyc_q)
               CYC_FETCH, CYC_READ: rd_n_d   = 1'b0;
               CYC_INTA:            inta_n_d = 1'b0;
               CYC_WRITE: begin
                  ad_out_d = dout;
                  ad_oe_d  = 1'b1;
                  wr_n_d   = 1'b0;
               end
               default: ;
            endcase
         end
         TS_TW: ;
         TS_T3: begin
            if ((cyc_q == CYC_FETCH || cyc_q == CYC_READ || cyc_q == CYC_INTA) && !din_vld_q) begin
               din_d     = ad_in;
               din_vld_d = 1'b1;
            end
         end
         TS_T4, TS_T5, TS_T6: begin
            ale_d    = 1'b0;
            rd_n_d   = 1'b1;
            wr_n_d   = 1'b1;
            inta_n_d = 1'b1;
            ad_oe_d  = 1'b0;
         end
         TS_TH, TS_TT: begin
            ale_d    = 1'b0;
            rd_n_d   = 1'b1;
            wr_n_d   = 1'b1;
            inta_n_d = 1'b1;
            ad_oe_d  = 1'b0;
            a_oe_d   = 1'b0;
            hlda_d   = (tstate == TS_TH);
         end
         default: begin
            // TR and the illegal codes 10-15 park the pins; only illegal codes flag err.
            cyc_d    = CYC_IDLE;
            ale_d    = 1'b0;
            rd_n_d   = 1'b1;
            wr_n_d   = 1'b1;
            inta_n_d = 1'b1;
            ad_out_d = '0;
            ad_oe_d  = 1'b0;
            a_hi_d   = '0;
            a_oe_d   = 1'b0;
            din_d    = '0;
            if (tstate != TS_TR) err_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!rst) begin
         cyc_q        <= CYC_IDLE;
         ale_q        <= 1'b0;
         rd_n_q       <= 1'b1;
         wr_n_q       <= 1'b1;
         inta_n_q     <= 1'b1;
         ad_out_q     <= '0;
         ad_oe_q      <= 1'b0;
         a_hi_q       <= '0;
         a_oe_q       <= 1'b0;
         din_q        <= '0;
         din_vld_q    <= 1'b0;
         hlda_q       <= 1'b0;
         err_q        <= 1'b0;
         ready_sync_q <= '0;
         hold_sync_q  <= '0;
      end else begin
         cyc_q        <= cyc_d;
         ale_q        <= ale_d;
         rd_n_q       <= rd_n_d;
         wr_n_q       <= wr_n_d;
         inta_n_q     <= inta_n_d;
         ad_out_q     <= ad_out_d;
         ad_oe_q      <= ad_oe_d;
         a_hi_q       <= a_hi_d;
         a_oe_q       <= a_oe_d;
         din_q        <= din_d;
         din_vld_q    <= din_vld_d;
         hlda_q       <= hlda_d;
         err_q        <= err_d;
         ready_sync_q <= ready_sync_d;
         hold_sync_q  <= hold_sync_d;
      end
   end

   assign ipin    = {hold_sync_q[SYNC_STAGES-1], ready_sync_q[SYNC_STAGES-1]};
   assign ale     = ale_q;
   assign rd_n    = rd_n_q;
   assign wr_n    = wr_n_q;
   assign inta_n  = inta_n_q;
   assign ad_out  = ad_out_q;
   assign ad_oe   = ad_oe_q;
   assign a_hi    = a_hi_q;
   assign a_oe    = a_oe_q;
   assign din     = din_q;
   assign din_vld = din_vld_q;
   assign hlda    = hlda_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bus_interface.sv
// Directed bench for bus_interface: fetch, wait-stated write, INTA, back-to-back read,
// synchronisers, hold, halt, illegal T-state and mid-cycle reset.
module tb_bus_interface;

   localparam logic [3:0] TR = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4,
                          T5 = 4'd5, T6 = 4'd6, TH = 4'd7, TW = 4'd8, TT = 4'd9;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  tstate;
   logic [2:0]  stat;
   logic [15:0] addr;
   logic [7:0]  dout;
   logic [7:0]  ad_in;
   logic        ready_pin;
   logic        hold_pin;
   logic [1:0]  ipin;
   logic        ale, rd_n, wr_n, inta_n;
   logic [7:0]  ad_out;
   logic        ad_oe;
   logic [7:0]  a_hi;
   logic        a_oe;
   logic [7:0]  din;
   logic        din_vld;
   logic        hlda;
   logic        err;

   int errors = 0;
   int checks = 0;

   bus_interface #(.DATASIZE(8), .ADDRSIZE(16), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .tstate   (tstate),
      .stat     (stat),
      .addr     (addr),
      .dout     (dout),
      .ad_in    (ad_in),
      .ready_pin(ready_pin),
      .hold_pin (hold_pin),
      .ipin     (ipin),
      .ale      (ale),
      .rd_n     (rd_n),
      .wr_n     (wr_n),
      .inta_n   (inta_n),
      .ad_out   (ad_out),
      .ad_oe    (ad_oe),
      .a_hi     (a_hi),
      .a_oe     (a_oe),
      .din      (din),
      .din_vld  (din_vld),
      .hlda     (hlda),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply tstate, clock one edge, then settle 1 time unit before sampling.
   task automatic step(input logic [3:0] ts);
      tstate = ts;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ale"},    ale,    0);
      check({tag, "_rd_n"},   rd_n,   1);
      check({tag, "_wr_n"},   wr_n,   1);
      check({tag, "_inta_n"}, inta_n, 1);
      check({tag, "_ad_oe"},  ad_oe,  0);
      check({tag, "_a_oe"},   a_oe,   0);
      check({tag, "_ad_out"}, ad_out, 0);
      check({tag, "_a_hi"},   a_hi,   0);
      check({tag, "_din"},    din,    0);
      check({tag, "_vld"},    din_vld, 0);
      check({tag, "_hlda"},   hlda,   0);
      check({tag, "_err"},    err,    0);
   endtask

   initial begin
      rst = 1'b0; tstate = TR; stat = 3'b000; addr = 16'h0; dout = 8'h0;
      ad_in = 8'h0; ready_pin = 1'b0; hold_pin = 1'b0;
      step(TR);
      step(TR);
      check_reset_vals("rst0");
      check("rst0_ipin", ipin, 0);
      rst = 1'b1;

      // Opcode fetch at 0x1234
      stat = 3'b011; addr = 16'h1234;
      step(T1);
      check("f_t1_ale", ale, 1);
      check("f_t1_ahi", a_hi, 8'h12);
      check("f_t1_adout", ad_out, 8'h34);
      check("f_t1_adoe", ad_oe, 1);
      check("f_t1_aoe", a_oe, 1);
      check("f_t1_rd_n", rd_n, 1);
      stat = 3'b000; addr = 16'hFFFF;
      step(T2);
      check("f_t2_ale", ale, 0);
      check("f_t2_rd_n", rd_n, 0);
      check("f_t2_adoe", ad_oe, 0);
      check("f_t2_inta_n", inta_n, 1);
      ad_in = 8'hA5;
      step(T3);
      check("f_t3_rd_n", rd_n, 0);
      check("f_t3_din", din, 8'hA5);
      check("f_t3_vld", din_vld, 1);
      ad_in = 8'h00;
      step(T4);
      check("f_t4_rd_n", rd_n, 1);
      check("f_t4_vld", din_vld, 0);
      check("f_t4_din", din, 8'hA5);
      check("f_t4_ahi", a_hi, 8'h12);
      check("f_t4_aoe", a_oe, 1);

      // Write 0x5A to 0x8001 with two wait states
      stat = 3'b001; addr = 16'h8001;
      step(T1);
      check("w_t1_ahi", a_hi, 8'h80);
      check("w_t1_adout", ad_out, 8'h01);
      check("w_t1_wr_n", wr_n, 1);
      stat = 3'b011; dout = 8'h5A;
      step(T2);
      check("w_t2_wr_n", wr_n, 0);
      check("w_t2_adout", ad_out, 8'h5A);
      check("w_t2_adoe", ad_oe, 1);
      check("w_t2_rd_n", rd_n, 1);
      dout = 8'h00;
      for (int i = 0; i < 2; i++) begin
         step(TW);
         check($sformatf("w_tw%0d_wr_n", i), wr_n, 0);
         check($sformatf("w_tw%0d_adout", i), ad_out, 8'h5A);
         check($sformatf("w_tw%0d_adoe", i), ad_oe, 1);
         check($sformatf("w_tw%0d_vld", i), din_vld, 0);
      end
      ad_in = 8'hEE;
      step(T3);
      check("w_t3_wr_n", wr_n, 0);
      check("w_t3_adoe", ad_oe, 1);
      check("w_t3_vld", din_vld, 0);
      check("w_t3_din", din, 8'hA5);

      // Reset asserted for one edge while still in T3 with wr_n low
      rst = 1'b0;
      step(T3);
      check_reset_vals("rstw");
      rst = 1'b1;

      // INTA cycle followed back-to-back by a memory read
      stat = 3'b111; addr = 16'h0038;
      step(T1);
      check("i_t1_ale", ale, 1);
      step(T2);
      check("i_t2_inta_n", inta_n, 0);
      check("i_t2_rd_n", rd_n, 1);
      ad_in = 8'hFF;
      step(T3);
      check("i_t3_inta_n", inta_n, 0);
      check("i_t3_rd_n", rd_n, 1);
      check("i_t3_din", din, 8'hFF);
      check("i_t3_vld", din_vld, 1);
      stat = 3'b010; addr = 16'h2000;
      step(T1);
      check("b2b_inta_n", inta_n, 1);
      check("b2b_ale", ale, 1);
      check("b2b_vld", din_vld, 0);
      check("b2b_ahi", a_hi, 8'h20);
      step(T2);
      check("r_t2_rd_n", rd_n, 0);
      check("r_t2_inta_n", inta_n, 1);
      ad_in = 8'h3C;
      step(T3);
      check("r_t3_din", din, 8'h3C);
      check("r_t3_vld", din_vld, 1);
      step(T4);
      check("r_t4_rd_n", rd_n, 1);

      // READY synchroniser: visible exactly two edges after the pin rises
      ready_pin = 1'b1;
      step(T5);
      check("rdy_e1", ipin[0], 0);
      check("t5_aoe", a_oe, 1);
      step(T6);
      check("rdy_e2", ipin[0], 1);
      check("t6_adoe", ad_oe, 0);

      // HOLD synchroniser then three TH cycles
      hold_pin = 1'b1;
      step(T4);
      check("hld_e1", ipin[1], 0);
      step(T4);
      check("hld_e2", ipin[1], 1);
      check("pre_th_aoe", a_oe, 1);
      for (int i = 0; i < 3; i++) begin
         step(TH);
         check($sformatf("th%0d_hlda", i), hlda, 1);
         check($sformatf("th%0d_aoe", i), a_oe, 0);
         check($sformatf("th%0d_adoe", i), ad_oe, 0);
      end
      hold_pin = 1'b0;
      step(TT);
      check("tt_hlda", hlda, 0);
      check("tt_aoe", a_oe, 0);
      stat = 3'b000; addr = 16'h0000;
      step(T1);
      check("post_th_hlda", hlda, 0);
      check("post_th_aoe", a_oe, 1);

      // Illegal T-state code is sticky until reset
      step(4'd12);
      check("ill_err", err, 1);
      check("ill_ale", ale, 0);
      check("ill_aoe", a_oe, 0);
      check("ill_ipin0", ipin[0], 1);
      step(T1);
      check("ill_t1_err", err, 1);
      check("ill_t1_ale", ale, 1);
      step(TR);
      check("ill_tr_err", err, 1);
      rst = 1'b0;
      step(TR);
      check("ill_rst_err", err, 0);
      check("ill_rst_ipin", ipin, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
